// File: rtl/rs_decoder_16_8.sv
// Shortened RS(16,8) decoder over GF(2^8), poly 0x11D, first root alpha^0.
// Optional status outputs (dec_fail, err_num) are enabled with macro RS_DEC_STATUS_EN.
module rs_decoder_16_8 (
   input  logic       clk,
   input  logic       rst,
   input  logic       din_val,
   input  logic       din_sop,
   input  logic       din_eop,
   input  logic [7:0] din,
   output logic       symb_out_val,
   output logic [7:0] symb_out_cnt,
   output logic [7:0] symb_corrected
`ifdef RS_DEC_STATUS_EN
   ,
   output logic       dec_fail,
   output logic [2:0] err_num
`endif
);

   localparam int unsigned SYM_W = 8;
   localparam int unsigned N     = 16;
   localparam int unsigned NSYN  = 8;
   localparam int unsigned T_MAX = 4;
   localparam int unsigned LAM_N = NSYN + 1;
   localparam logic [SYM_W-1:0] ALPHA     = 8'h02;
   localparam logic [SYM_W-1:0] ALPHA_INV = 8'h8E;

   // GF(2^8) multiply, reduction by 0x11D
   function automatic logic [SYM_W-1:0] gf_mul(input logic [SYM_W-1:0] a, input logic [SYM_W-1:0] b);
      logic [SYM_W-1:0] p;
      logic [SYM_W-1:0] aa;
      p  = '0;
      aa = a;
      for (int i = 0; i < int'(SYM_W); i++) begin
         if (b[i]) p = p ^ aa;
         aa = {aa[SYM_W-2:0], 1'b0} ^ (aa[SYM_W-1] ? 8'h1D : 8'h00);
      end
      return p;
   endfunction

   // Inverse as a^254; maps 0 to 0
   function automatic logic [SYM_W-1:0] gf_inv(input logic [SYM_W-1:0] a);
      logic [SYM_W-1:0] r;
      logic [SYM_W-1:0] p;
      r = 8'h01;
      p = a;
      for (int i = 0; i < 8; i++) begin
         if (i != 0) r = gf_mul(r, p);
         p = gf_mul(p, p);
      end
      return r;
   endfunction

   typedef enum logic [2:0] {S_IDLE, S_BM, S_OMEGA, S_CHIEN, S_OUT} state_t;

   state_t           state, state_n;
   logic [3:0]       step;
   logic [SYM_W-1:0] rx    [N];
   logic [SYM_W-1:0] err   [N];
   logic [SYM_W-1:0] syn   [NSYN];
   logic [SYM_W-1:0] lam   [LAM_N];
   logic [SYM_W-1:0] bb    [LAM_N];
   logic [SYM_W-1:0] lam_n [LAM_N];
   logic [SYM_W-1:0] bb_n  [LAM_N];
   logic [SYM_W-1:0] om    [NSYN];
   logic [SYM_W-1:0] om_c  [NSYN];
   logic [4:0]       in_cnt;
   logic             in_frame;
   logic [3:0]       deg_l, deg_l_n;
   logic [SYM_W-1:0] gamma, gamma_n, delta_c;
   logic             grow_c;
   logic [SYM_W-1:0] xinv, xpos;
   logic [SYM_W-1:0] x2_c, lam_eval_c, dlam_c, om_eval_c, e_val_c;
   logic [4:0]       roots;
   logic             accept_c, frame_done_c, fail_c;

   assign accept_c     = (state == S_IDLE) && din_val;
   assign frame_done_c = accept_c && !din_sop && in_frame && (in_cnt == 5'd15) && din_eop;
   assign fail_c       = (deg_l > 4'(T_MAX)) || ({1'b0, deg_l} != roots);

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:  if (frame_done_c) state_n = S_BM;
         S_BM:    if (step == 4'd7) state_n = S_OMEGA;
         S_OMEGA: state_n = S_CHIEN;
         S_CHIEN: if (step == 4'd15) state_n = S_OUT;
         S_OUT:   if (step == 4'd15) state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   // Per-state step counter, restarts on every state change
   always_ff @(posedge clk) begin
      if (rst)                  step <= '0;
      else if (state_n != state) step <= '0;
      else                      step <= step + 4'd1;
   end

   // Frame capture and Horner syndrome accumulation (first symbol is x^15)
   always_ff @(posedge clk) begin
      if (rst) begin
         in_cnt   <= '0;
         in_frame <= 1'b0;
         for (int i = 0; i < int'(N); i++)    rx[i]  <= '0;
         for (int j = 0; j < int'(NSYN); j++) syn[j] <= '0;
      end else if (accept_c) begin
         if (din_sop) begin
            rx[0]    <= din;
            in_cnt   <= 5'd1;
            in_frame <= !din_eop;
            for (int j = 0; j < int'(NSYN); j++) syn[j] <= din;
         end else if (in_frame) begin
            rx[in_cnt[3:0]] <= din;
            in_cnt          <= in_cnt + 5'd1;
            if ((in_cnt == 5'd15) || din_eop) in_frame <= 1'b0;
            for (int j = 0; j < int'(NSYN); j++) syn[j] <= gf_mul(syn[j], 8'(1 << j)) ^ din;
         end
      end
   end

   // Inversionless Berlekamp-Massey step; Lambda ends up scaled, which Forney cancels
   always_comb begin
      delta_c = '0;
      for (int i = 0; i < int'(LAM_N); i++)
         if (i <= int'(step)) delta_c = delta_c ^ gf_mul(lam[i], syn[3'(int'(step) - i)]);
      grow_c   = (delta_c != '0) && (({1'b0, deg_l} << 1) <= {1'b0, step});
      lam_n[0] = gf_mul(gamma, lam[0]);
      for (int i = 1; i < int'(LAM_N); i++) lam_n[i] = gf_mul(gamma, lam[i]) ^ gf_mul(delta_c, bb[i-1]);
      bb_n[0] = '0;
      for (int i = 1; i < int'(LAM_N); i++) bb_n[i] = bb[i-1];
      deg_l_n = deg_l;
      gamma_n = gamma;
      if (grow_c) begin
         for (int i = 0; i < int'(LAM_N); i++) bb_n[i] = lam[i];
         deg_l_n = 4'(step + 4'd1 - deg_l);
         gamma_n = delta_c;
      end
   end

   // Evaluator Omega = S*Lambda mod x^8, then Chien/Forney terms at X^-1
   always_comb begin
      for (int i = 0; i < int'(NSYN); i++) begin
         om_c[i] = '0;
         for (int j = 0; j <= i; j++) om_c[i] = om_c[i] ^ gf_mul(syn[j], lam[i-j]);
      end
      lam_eval_c = '0;
      for (int i = int'(LAM_N) - 1; i >= 0; i--) lam_eval_c = gf_mul(lam_eval_c, xinv) ^ lam[i];
      x2_c   = gf_mul(xinv, xinv);
      dlam_c = '0;
      for (int i = 7; i >= 1; i -= 2) dlam_c = gf_mul(dlam_c, x2_c) ^ lam[i];
      om_eval_c = '0;
      for (int i = int'(NSYN) - 1; i >= 0; i--) om_eval_c = gf_mul(om_eval_c, xinv) ^ om[i];
      e_val_c = gf_mul(gf_mul(xpos, om_eval_c), gf_inv(dlam_c));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         deg_l <= '0;
         gamma <= 8'h01;
         xinv  <= 8'h01;
         xpos  <= 8'h01;
         roots <= '0;
         for (int i = 0; i < int'(LAM_N); i++) begin lam[i] <= '0; bb[i] <= '0; end
         for (int i = 0; i < int'(NSYN); i++)  om[i]  <= '0;
         for (int i = 0; i < int'(N); i++)     err[i] <= '0;
      end else begin
         case (state)
            S_IDLE: if (frame_done_c) begin
               deg_l <= '0;
               gamma <= 8'h01;
               xinv  <= 8'h01;
               xpos  <= 8'h01;
               roots <= '0;
               for (int i = 0; i < int'(LAM_N); i++) begin
                  lam[i] <= (i == 0) ? 8'h01 : 8'h00;
                  bb[i]  <= (i == 0) ? 8'h01 : 8'h00;
               end
               for (int i = 0; i < int'(N); i++) err[i] <= '0;
            end
            S_BM: begin
               for (int i = 0; i < int'(LAM_N); i++) begin lam[i] <= lam_n[i]; bb[i] <= bb_n[i]; end
               deg_l <= deg_l_n;
               gamma <= gamma_n;
            end
            S_OMEGA: for (int i = 0; i < int'(NSYN); i++) om[i] <= om_c[i];
            // Step s tests X = alpha^s, i.e. symbol index 15-s
            S_CHIEN: begin
               if (lam_eval_c == '0) begin
                  err[4'(4'd15 - step)] <= e_val_c;
                  roots                 <= roots + 5'd1;
               end
               xinv <= gf_mul(xinv, ALPHA_INV);
               xpos <= gf_mul(xpos, ALPHA);
            end
            default: ;
         endcase
      end
   end

   // Output burst; uncorrectable frames pass through untouched
   always_ff @(posedge clk) begin
      if (rst || (state != S_OUT)) begin
         symb_out_val   <= 1'b0;
         symb_out_cnt   <= '0;
         symb_corrected <= '0;
      end else begin
         symb_out_val   <= 1'b1;
         symb_out_cnt   <= {4'b0000, step};
         symb_corrected <= rx[step] ^ (fail_c ? 8'h00 : err[step]);
      end
   end

`ifdef RS_DEC_STATUS_EN
   always_ff @(posedge clk) begin
      if (rst || (state != S_OUT)) begin
         dec_fail <= 1'b0;
         err_num  <= '0;
      end else if (step == 4'd0) begin
         dec_fail <= fail_c;
         err_num  <= fail_c ? 3'd0 : 3'(roots);
      end
   end
`endif

endmodule

// File: tb/tb_rs_decoder_16_8.sv
// Scoreboard bench for rs_decoder_16_8: table-based GF model, long-division encoder, random error injection.
module tb_rs_decoder_16_8;

   logic       clk     = 1'b0;
   logic       rst     = 1'b1;
   logic       din_val = 1'b0;
   logic       din_sop = 1'b0;
   logic       din_eop = 1'b0;
   logic [7:0] din     = 8'h00;
   logic       symb_out_val;
   logic [7:0] symb_out_cnt;
   logic [7:0] symb_corrected;
`ifdef RS_DEC_STATUS_EN
   logic       dec_fail;
   logic [2:0] err_num;
   logic       cap_fail;
   logic [2:0] cap_num;
`endif

   rs_decoder_16_8 dut (
      .clk(clk), .rst(rst), .din_val(din_val), .din_sop(din_sop), .din_eop(din_eop), .din(din),
      .symb_out_val(symb_out_val), .symb_out_cnt(symb_out_cnt), .symb_corrected(symb_corrected)
`ifdef RS_DEC_STATUS_EN
      , .dec_fail(dec_fail), .err_num(err_num)
`endif
   );

   typedef logic [15:0][7:0] frame_t;
   typedef struct packed {
      frame_t     cw;
      frame_t     rx;
      logic [4:0] nerr;
      logic       exact;
   } exp_t;

   int     gexp [512];
   int     glog [256];
   int     gpoly[9];
   exp_t   sb[$];
   int     errors  = 0;
   int     checks  = 0;
   int     cyc     = 0;
   int     last_eop = 0;
   int     lat_ref = -1;
   int     lat;
   int     idx = 0;
   frame_t got;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int gmul(input int a, input int b);
      if (a == 0 || b == 0) return 0;
      return gexp[glog[a] + glog[b]];
   endfunction

   // Systematic encoding: parity = info(x)*x^8 mod g(x), info symbol k at x^(15-k)
   function automatic frame_t encode(input frame_t info);
      int     p[16];
      int     c;
      frame_t cw;
      for (int i = 0; i < 16; i++) p[i] = 0;
      for (int k = 0; k < 8; k++) p[15-k] = int'(info[k]);
      for (int d = 15; d >= 8; d--) begin
         c = p[d];
         if (c != 0) for (int j = 0; j <= 8; j++) p[d-8+j] ^= gmul(c, gpoly[j]);
      end
      cw = '0;
      for (int k = 0; k < 8; k++) cw[k] = info[k];
      for (int q = 0; q < 8; q++) cw[8+q] = 8'(p[7-q]);
      return cw;
   endfunction

   function automatic bit is_codeword(input frame_t f);
      int s;
      for (int j = 0; j < 8; j++) begin
         s = 0;
         for (int n = 0; n < 16; n++) s ^= gmul(int'(f[n]), gexp[(j * (15 - n)) % 255]);
         if (s != 0) return 1'b0;
      end
      return 1'b1;
   endfunction

   function automatic frame_t rand_cw();
      frame_t f;
      f = '0;
      for (int k = 0; k < 8; k++) f[k] = 8'($urandom);
      return encode(f);
   endfunction

   task automatic drive(input logic v, input logic s, input logic e, input logic [7:0] d);
      din_val = v; din_sop = s; din_eop = e; din = d;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   // gap < 0 selects a random 0..2 idle cycles after each symbol
   task automatic send_frame(input frame_t f, input int n, input bit eop_last, input int gap);
      int g;
      for (int i = 0; i < n; i++) begin
         drive(1'b1, i == 0, eop_last && (i == n - 1), f[i]);
         if (eop_last && (i == n - 1)) last_eop = cyc;
         g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
         repeat (g) drive(1'b0, 1'b0, 1'b0, 8'h00);
      end
      din_val = 1'b0; din_sop = 1'b0; din_eop = 1'b0; din = 8'h00;
   endtask

   task automatic expect_frame(input frame_t cw, input frame_t r, input bit exact);
      exp_t e;
      int   d;
      d = 0;
      for (int n = 0; n < 16; n++) if (cw[n] != r[n]) d++;
      e.cw = cw; e.rx = r; e.nerr = 5'(d); e.exact = exact;
      sb.push_back(e);
   endtask

   task automatic wait_done(input string tag);
      int k;
      k = 0;
      while ((sb.size() != 0 || idx != 0) && k < 400) begin
         @(posedge clk);
         k++;
      end
      #1;
      checks++;
      if (k >= 400) begin
         errors++;
         $display("FAIL timeout_%s: %0d frames still pending after %0d cycles, want 0", tag, sb.size(), k);
         sb.delete();
      end
      idle(2);
   endtask

   task automatic rand_case(input int nerr, input bit exact, input int gap);
      frame_t      cw, r;
      logic [15:0] used;
      int          p, k;
      cw = rand_cw(); r = cw; used = '0; k = 0;
      while (k < nerr) begin
         p = int'($urandom_range(0, 15));
         if (!used[p]) begin
            used[p] = 1'b1;
            r[p] = r[p] ^ 8'($urandom_range(1, 255));
            k++;
         end
      end
      expect_frame(cw, r, exact);
      send_frame(r, 16, 1'b1, gap);
      wait_done("rand");
   endtask

   task automatic check_frame();
      exp_t e;
      int   d;
      bit   ok;
      if (sb.size() == 0) begin
         checks++; errors++;
         $display("FAIL unexpected_burst: got a 16-symbol burst, want no output");
         return;
      end
      e = sb.pop_front();
      d = 0;
      for (int n = 0; n < 16; n++) if (got[n] != e.rx[n]) d++;
      if (e.exact) begin
         for (int n = 0; n < 16; n++) begin
            checks++;
            if (got[n] !== e.cw[n]) begin
               errors++;
               $display("FAIL sym[%0d]: got %02h want %02h (injected errors %0d)", n, got[n], e.cw[n], e.nerr);
            end
         end
      end else begin
         ok = (d == 0) || (d <= 4 && is_codeword(got));
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL uncorrectable_out: %0d symbols changed, codeword=%0d; want unchanged or a codeword within 4", d, is_codeword(got));
         end
      end
`ifdef RS_DEC_STATUS_EN
      checks++;
      if (e.exact) begin
         if (cap_fail !== 1'b0 || cap_num !== 3'(e.nerr)) begin
            errors++;
            $display("FAIL status: got dec_fail=%0d err_num=%0d want 0/%0d", cap_fail, cap_num, e.nerr);
         end
      end else if (cap_fail !== (d == 0) || cap_num !== ((d == 0) ? 3'd0 : 3'(d))) begin
         errors++;
         $display("FAIL status: got dec_fail=%0d err_num=%0d want %0d/%0d", cap_fail, cap_num, d == 0, (d == 0) ? 0 : d);
      end
`endif
   endtask

   // Output monitor: collects bursts, checks ordering, latency and idle outputs
   initial begin : monitor
      forever begin
         @(negedge clk);
         if (rst) idx = 0;
         else if (symb_out_val) begin
            checks++;
            if (symb_out_cnt != 8'(idx)) begin
               errors++;
               $display("FAIL out_cnt: got %0d want %0d", symb_out_cnt, idx);
            end
            if (idx == 0) begin
               lat = cyc - last_eop;
               checks++;
               if (lat < 1 || lat > 128 || (lat_ref >= 0 && lat != lat_ref)) begin
                  errors++;
                  $display("FAIL latency: got %0d cycles want fixed <=128 (first seen %0d)", lat, lat_ref);
               end
               if (lat_ref < 0) lat_ref = lat;
`ifdef RS_DEC_STATUS_EN
               cap_fail = dec_fail;
               cap_num  = err_num;
`endif
            end
            got[idx] = symb_corrected;
            idx++;
            if (idx == 16) begin
               idx = 0;
               check_frame();
            end
         end else begin
            checks++;
            if (idx != 0 || symb_out_cnt != 8'd0 || symb_corrected != 8'd0) begin
               errors++;
               $display("FAIL idle_out: burst pos %0d cnt %0d sym %02h, want 0/0/00", idx, symb_out_cnt, symb_corrected);
            end
         end
      end
   end

   initial begin : stim
      frame_t info, cw0, r, cw1;
      int     x;
      x = 1;
      for (int i = 0; i < 255; i++) begin
         gexp[i] = x; gexp[i+255] = x; glog[x] = i;
         x = x << 1;
         if ((x & 256) != 0) x ^= 'h11D;
      end
      gexp[510] = 0; gexp[511] = 0; glog[0] = 0;
      for (int k = 0; k < 9; k++) gpoly[k] = (k == 0) ? 1 : 0;
      for (int i = 0; i < 8; i++) begin
         for (int k = 8; k >= 1; k--) gpoly[k] = gpoly[k-1] ^ gmul(gpoly[k], gexp[i]);
         gpoly[0] = gmul(gpoly[0], gexp[i]);
      end

      repeat (3) @(posedge clk);
      #1;
      checks += 3;
      if (symb_out_val !== 1'b0)    begin errors++; $display("FAIL reset_val: got %0b want 0", symb_out_val); end
      if (symb_out_cnt !== 8'd0)    begin errors++; $display("FAIL reset_cnt: got %0d want 0", symb_out_cnt); end
      if (symb_corrected !== 8'd0)  begin errors++; $display("FAIL reset_sym: got %02h want 00", symb_corrected); end
      rst = 1'b0;
      idle(2);

      info = '0;
      for (int k = 0; k < 8; k++) info[k] = 8'(k);
      cw0 = encode(info);

      // clean codeword of info 0..7
      expect_frame(cw0, cw0, 1'b1);
      send_frame(cw0, 16, 1'b1, 0);
      wait_done("clean");

      // three errors
      r = cw0; r[2] ^= 8'h11; r[8] ^= 8'h22; r[13] ^= 8'h33;
      expect_frame(cw0, r, 1'b1);
      send_frame(r, 16, 1'b1, 0);
      wait_done("err3");

      // four errors at both ends
      r = cw0; r[0] ^= 8'hFF; r[7] ^= 8'h01; r[8] ^= 8'h80; r[15] ^= 8'h5A;
      expect_frame(cw0, r, 1'b1);
      send_frame(r, 16, 1'b1, 0);
      wait_done("err4");

      // five errors: pass-through or a valid miscorrection
      r = cw0;
      for (int k = 0; k < 5; k++) r[k] ^= 8'h01;
      expect_frame(cw0, r, 1'b0);
      send_frame(r, 16, 1'b1, 0);
      wait_done("err5");

      // reset after 8 symbols, then a clean frame
      send_frame(cw0, 8, 1'b0, 0);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      cw1 = rand_cw();
      expect_frame(cw1, cw1, 1'b1);
      send_frame(cw1, 16, 1'b1, 0);
      wait_done("after_rst");

      // gap-free vs 3-cycle gaps with the same received word
      r = cw1; r[5] ^= 8'h3C; r[11] ^= 8'hA7;
      expect_frame(cw1, r, 1'b1);
      send_frame(r, 16, 1'b1, 0);
      wait_done("nogap");
      expect_frame(cw1, r, 1'b1);
      send_frame(r, 16, 1'b1, 3);
      wait_done("gap3");

      // discarded frames: early eop, missing eop, then sop restart mid-frame
      send_frame(cw0, 10, 1'b1, 0);
      idle(3);
      send_frame(cw0, 16, 1'b0, 0);
      idle(60);
      send_frame(cw1, 5, 1'b0, 1);
      expect_frame(cw0, cw0, 1'b1);
      send_frame(cw0, 16, 1'b1, 0);
      wait_done("restart");

      for (int t = 0; t < 24; t++) rand_case(int'($urandom_range(0, 4)), 1'b1, -1);
      for (int t = 0; t < 6; t++)  rand_case(int'($urandom_range(5, 8)), 1'b0, -1);

      idle(50);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL leftover: got %0d frames without output, want 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rs_decoder_16_8.md
RS_DECODER_16_8 -- requirements
Module: rs_decoder_16_8

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all logic on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: din_val  input  1  input symbol valid.
REQ-004 SHALL have port: din_sop  input  1  first symbol of frame, qualified by din_val.
REQ-005 SHALL have port: din_eop  input  1  16th (last) symbol of frame, qualified by din_val.
REQ-006 SHALL have port: din  input  8  received symbol.
REQ-007 SHALL have port: symb_out_val  output  1  output symbol valid.
REQ-008 SHALL have port: symb_out_cnt  output  8  index 0..15 of the current output symbol.
REQ-009 SHALL have port: symb_corrected  output  8  corrected symbol.

Function
REQ-010 SHALL decode shortened RS(16,8) over GF(2^8): primitive polynomial 0x11D, alpha = 0x02, generator g(x) = product over i = 0..7 of (x + alpha^i), so first consecutive root is alpha^0.
REQ-011 SHALL map the first received symbol to the x^15 coefficient and the 16th to x^0; symbols 0..7 are info, 8..15 are parity.
REQ-012 SHALL use this field, generator and ordering identically to rs_encoder_16_8 (8 info in, same 8 info followed by 8 parity out).
REQ-013 SHALL accept a symbol only in cycles with din_val=1.
REQ-014 SHALL start a frame when din_val=1 and din_sop=1; that symbol is index 0.
REQ-015 SHALL complete a frame at the 16th accepted symbol, which must carry din_eop=1.
REQ-016 SHALL discard a frame that gets din_eop before 16 symbols, or 16 symbols without din_eop, with no output; a fresh sop restarts the count at 0.
REQ-017 SHALL tolerate idle cycles (din_val=0) inside a frame.
REQ-018 SHALL compute 8 syndromes S0..S7, solve the error locator (Berlekamp-Massey or equivalent), find error positions (Chien search) and error values (Forney).
REQ-019 SHALL correct any pattern of up to 4 symbol errors at any of the 16 positions.
REQ-020 SHALL treat a frame as uncorrectable when the locator degree exceeds 4 or the root count differs from the locator degree, and then output received symbols unchanged.
REQ-021 SHALL pass an all-zero-syndrome frame through unchanged.
REQ-022 SHALL output all 16 symbols in order on 16 consecutive cycles, symb_out_val=1 and symb_out_cnt=0..15.
REQ-023 SHALL start that output burst no later than 128 cycles after the eop cycle, with a fixed latency independent of error count.
REQ-024 SHALL hold symb_out_val=0, symb_out_cnt=0 and symb_corrected=0 outside bursts.
REQ-025 SHALL ignore din_val, din_sop and din_eop from the eop cycle until the last output symbol (busy); symbols sent during busy are lost.

Reset
REQ-026 SHALL, with rst=1 at a clock edge, clear all state: frame counter, syndromes, decoder state machine to IDLE, symb_out_val=0, symb_out_cnt=0, symb_corrected=0.
REQ-027 SHALL, on reset mid-frame or mid-burst, abort the frame, produce no further output, and accept a new sop on the first cycle after rst=0.

Configuration
REQ-028 SHALL, with macro RS_DEC_STATUS_EN defined, add outputs dec_fail (1 bit) and err_num (3 bits); both are valid with symb_out_cnt=0 and held through the burst.
REQ-029 SHALL drive dec_fail=1 for uncorrectable frames and err_num = number of symbols corrected (0..4, 0 when dec_fail=1).
REQ-030 SHALL, without RS_DEC_STATUS_EN, have neither port and no status logic; correction behaviour is identical either way.

Verification
REQ-031 SHALL cover: encoder codeword of info 0..7 with no errors -> 16 outputs, symbols 0..7 = 0..7, parity equals encoder parity, err_num=0.
REQ-032 SHALL cover: same codeword XOR 0x11 at index 2, 0x22 at index 8, 0x33 at index 13 -> all 16 original symbols restored, err_num=3.
REQ-033 SHALL cover: 4 errors at indices 0, 7, 8, 15 (XOR 0xFF, 0x01, 0x80, 0x5A) -> full codeword restored, err_num=4.
REQ-034 SHALL cover: 5 errors at indices 0..4 (XOR 0x01) -> when not miscorrected, received symbols output unchanged with dec_fail=1.
REQ-035 SHALL cover: rst=1 for one cycle after 8 input symbols, then a full clean frame -> only the second frame is output, correct, within 128 cycles of its eop.
REQ-036 SHALL cover: din_val gaps of 3 cycles between every input symbol -> output identical to the gap-free case.
